// File: rtl/seq_tx_1011_if.sv
// Payload handshake and serial-output bundle for seq_tx_1011.
// The transmitter connects through the slave modport; the upstream source uses the master modport.
interface seq_tx_1011_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;
   logic              out_bit;
   logic              tx_busy;
   logic              frame_done;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready,
      input  out_bit,
      input  tx_busy,
      input  frame_done
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready,
      output out_bit,
      output tx_busy,
      output frame_done
   );
endinterface

// File: rtl/seq_tx_1011.sv
// Framed serial transmitter: sync word, MSB-first payload, even parity, then forced zero gap.
// Each serial bit is held for CLKS_PER_BIT cycles; all outputs are registered.
module seq_tx_1011 #(
   parameter int unsigned       DATA_W       = 8,
   parameter int unsigned       SYNC_W       = 4,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011,
   parameter int unsigned       GAP_BITS     = 2,
   parameter int unsigned       CLKS_PER_BIT = 1
) (
   input logic          clk,
   input logic          reset,
   seq_tx_1011_if.slave bus
);
   localparam int unsigned MAX_SD   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int unsigned MAX_BITS = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
   localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
   localparam int unsigned DIV_W    = $clog2(CLKS_PER_BIT + 1);

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_PARITY,
      ST_GAP
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [DATA_W-1:0] r_shift;
   logic [SYNC_W-1:0] r_sync;
   logic              r_parity;
   logic              r_out_bit;
   logic              r_busy;
   logic              r_done;
   logic              r_ready;

   logic              w_accept;
   logic              w_bit_end;

   assign w_accept  = bus.data_valid && r_ready;
   assign w_bit_end = (r_div_cnt == DIV_LAST);

   assign bus.data_ready = r_ready;
   assign bus.out_bit    = r_out_bit;
   assign bus.tx_busy    = r_busy;
   assign bus.frame_done = r_done;

   // out_bit is loaded one bit ahead: each transition presents the first bit of the next field.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
         r_shift   <= '0;
         r_sync    <= '0;
         r_parity  <= 1'b0;
         r_out_bit <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE) begin
            r_div_cnt <= w_bit_end ? '0 : r_div_cnt + DIV_W'(1);
         end
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state   <= ST_SYNC;
                  r_bit_cnt <= '0;
                  r_div_cnt <= '0;
                  r_shift   <= bus.data_in;
                  r_parity  <= ^bus.data_in;
                  r_out_bit <= SYNC_PATTERN[SYNC_W-1];
                  r_sync    <= SYNC_PATTERN << 1;
                  r_busy    <= 1'b1;
                  r_ready   <= 1'b0;
               end
            end
            ST_SYNC: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == SYNC_LAST) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                     r_out_bit <= r_shift[DATA_W-1];
                     r_shift   <= r_shift << 1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     r_out_bit <= r_sync[SYNC_W-1];
                     r_sync    <= r_sync << 1;
                  end
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == DATA_LAST) begin
                     r_state   <= ST_PARITY;
                     r_bit_cnt <= '0;
                     r_out_bit <= r_parity;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     r_out_bit <= r_shift[DATA_W-1];
                     r_shift   <= r_shift << 1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state   <= ST_GAP;
                  r_bit_cnt <= '0;
                  r_out_bit <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            ST_GAP: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == GAP_LAST) begin
                     r_state   <= ST_IDLE;
                     r_bit_cnt <= '0;
                     r_busy    <= 1'b0;
                     r_ready   <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_tx_1011.sv
// Self-checking bench for seq_tx_1011: a default instance and a CLKS_PER_BIT=3 instance,
// compared against a frame model built from the sync/payload/parity/gap rules.
module tb_seq_tx_1011;
   localparam int unsigned DW  = 8;
   localparam int unsigned SW  = 4;
   localparam int unsigned GAP = 2;
   localparam logic [3:0]  SP  = 4'b1011;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   bit   exp_bits[$];

   always #5 clk = ~clk;

   seq_tx_1011_if #(.DATA_W(DW)) bus1 ();
   seq_tx_1011_if #(.DATA_W(DW)) bus3 ();

   seq_tx_1011 #(
      .DATA_W(DW), .SYNC_W(SW), .SYNC_PATTERN(SP), .GAP_BITS(GAP), .CLKS_PER_BIT(1)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave)
   );

   seq_tx_1011 #(
      .DATA_W(DW), .SYNC_W(SW), .SYNC_PATTERN(SP), .GAP_BITS(GAP), .CLKS_PER_BIT(3)
   ) dut3 (
      .clk(clk), .reset(reset), .bus(bus3.slave)
   );

   // Expected per-bit stream of one frame including the trailing gap zeros.
   function automatic void build_frame(input logic [DW-1:0] d);
      int sp_val;
      exp_bits.delete();
      sp_val = int'(SP);
      for (int i = SW - 1; i >= 0; i--) exp_bits.push_back(((sp_val >> i) & 1) == 1);
      for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(((int'(d) >> i) & 1) == 1);
      exp_bits.push_back(($countones(d) % 2) == 1);
      for (int i = 0; i < GAP; i++) exp_bits.push_back(1'b0);
   endfunction

   task automatic wait_ready1();
      int w = 0;
      while (bus1.data_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (w >= 100) begin
         fails++;
         $display("FAIL ready_timeout: data_ready=%b after %0d cycles, required 1", bus1.data_ready, w);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus1.data_valid = 1'b1;
      bus1.data_in    = 8'hA5;
      bus3.data_valid = 1'b1;
      bus3.data_in    = 8'h5A;
      repeat (3) @(negedge clk);
      tests++;
      if (bus1.data_ready !== 1'b1 || bus1.tx_busy !== 1'b0 || bus1.out_bit !== 1'b0 || bus1.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_state1: ready=%b busy=%b out=%b done=%b, required 1 0 0 0",
                  bus1.data_ready, bus1.tx_busy, bus1.out_bit, bus1.frame_done);
      end
      tests++;
      if (bus3.data_ready !== 1'b1 || bus3.tx_busy !== 1'b0 || bus3.out_bit !== 1'b0 || bus3.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_state3: ready=%b busy=%b out=%b done=%b, required 1 0 0 0",
                  bus3.data_ready, bus3.tx_busy, bus3.out_bit, bus3.frame_done);
      end
      reset = 1'b0;
      bus1.data_valid = 1'b0;
      bus3.data_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (bus1.tx_busy !== 1'b0 || bus1.data_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_no_accept: busy=%b ready=%b, required 0 1", bus1.tx_busy, bus1.data_ready);
      end
   endtask

   task automatic test_frame(input logic [DW-1:0] d, input bit change_mid);
      logic exp_done;
      wait_ready1();
      bus1.data_in    = d;
      bus1.data_valid = 1'b1;
      @(negedge clk);
      bus1.data_valid = 1'b0;
      build_frame(d);
      for (int k = 0; k < exp_bits.size(); k++) begin
         if (change_mid && k == 6) bus1.data_in = ~d;
         exp_done = (k == int'(SW + DW + 1));
         tests++;
         if (bus1.out_bit !== exp_bits[k]) begin
            fails++;
            $display("FAIL frame_bit d=%h k=%0d: out_bit=%b, required %b", d, k, bus1.out_bit, exp_bits[k]);
         end
         tests++;
         if (bus1.tx_busy !== 1'b1 || bus1.data_ready !== 1'b0) begin
            fails++;
            $display("FAIL frame_busy d=%h k=%0d: busy=%b ready=%b, required 1 0", d, k, bus1.tx_busy, bus1.data_ready);
         end
         tests++;
         if (bus1.frame_done !== exp_done) begin
            fails++;
            $display("FAIL frame_done d=%h k=%0d: frame_done=%b, required %b", d, k, bus1.frame_done, exp_done);
         end
         @(negedge clk);
      end
      tests++;
      if (bus1.out_bit !== 1'b0 || bus1.tx_busy !== 1'b0 || bus1.data_ready !== 1'b1 || bus1.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL frame_idle d=%h: out=%b busy=%b ready=%b done=%b, required 0 0 1 0",
                  d, bus1.out_bit, bus1.tx_busy, bus1.data_ready, bus1.frame_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] pay[2];
      pay[0] = 8'h3C;
      pay[1] = 8'hC3;
      wait_ready1();
      bus1.data_in    = pay[0];
      bus1.data_valid = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 2; f++) begin
         build_frame(pay[f]);
         for (int k = 0; k < exp_bits.size(); k++) begin
            if (f == 0 && k == 0) bus1.data_in = pay[1];
            tests++;
            if (bus1.out_bit !== exp_bits[k] || bus1.data_ready !== 1'b0) begin
               fails++;
               $display("FAIL b2b_frame f=%0d k=%0d: out=%b ready=%b, required %b 0",
                        f, k, bus1.out_bit, bus1.data_ready, exp_bits[k]);
            end
            @(negedge clk);
         end
         tests++;
         if (bus1.out_bit !== 1'b0 || bus1.data_ready !== 1'b1 || bus1.tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle f=%0d: out=%b ready=%b busy=%b, required 0 1 0",
                     f, bus1.out_bit, bus1.data_ready, bus1.tx_busy);
         end
         if (f == 1) bus1.data_valid = 1'b0;
         @(negedge clk);
      end
      tests++;
      if (bus1.tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_stop: busy=%b after valid dropped, required 0", bus1.tx_busy);
      end
   endtask

   task automatic test_slow_bits();
      int w = 0;
      int busy_cyc = 0;
      int done_cnt = 0;
      int done_at = -1;
      while (bus3.data_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      bus3.data_in    = 8'hA5;
      bus3.data_valid = 1'b1;
      @(negedge clk);
      bus3.data_valid = 1'b0;
      build_frame(8'hA5);
      for (int k = 0; k < exp_bits.size() * 3; k++) begin
         if (k == 10) bus3.data_in = 8'h00;
         tests++;
         if (bus3.out_bit !== exp_bits[k / 3]) begin
            fails++;
            $display("FAIL slow_bit k=%0d: out_bit=%b, required %b", k, bus3.out_bit, exp_bits[k / 3]);
         end
         if (bus3.tx_busy === 1'b1) busy_cyc++;
         if (bus3.frame_done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         if (bus3.tx_busy === 1'b1) busy_cyc++;
         if (bus3.frame_done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      tests++;
      if (busy_cyc != 45) begin
         fails++;
         $display("FAIL slow_busy_len: tx_busy cycles=%0d, required 45", busy_cyc);
      end
      tests++;
      if (done_cnt != 1 || done_at != 39) begin
         fails++;
         $display("FAIL slow_done: pulses=%0d at=%0d, required 1 at 39", done_cnt, done_at);
      end
   endtask

   task automatic test_reset_abort();
      logic [DW-1:0] d;
      int bad = 0;
      d = DW'($urandom);
      wait_ready1();
      bus1.data_in    = d;
      bus1.data_valid = 1'b1;
      @(negedge clk);
      bus1.data_valid = 1'b0;
      for (int k = 0; k < int'(SW + 3); k++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if (bus1.out_bit !== 1'b0 || bus1.data_ready !== 1'b1 || bus1.tx_busy !== 1'b0 || bus1.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL abort_state: out=%b ready=%b busy=%b done=%b, required 0 1 0 0",
                  bus1.out_bit, bus1.data_ready, bus1.tx_busy, bus1.frame_done);
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus1.out_bit !== 1'b0 || bus1.frame_done !== 1'b0 || bus1.tx_busy !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
      end
      test_frame(DW'($urandom), 1'b1);
   endtask

   task automatic test_loopback();
      logic [3:0] hist = '0;
      int det = 0;
      wait_ready1();
      bus1.data_in    = 8'h00;
      bus1.data_valid = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 48; c++) begin
         hist = {hist[2:0], bus1.out_bit};
         if (hist == 4'b1011) begin
            det++;
            tests++;
            if ((c % 16) != int'(SW - 1)) begin
               fails++;
               $display("FAIL loop_pos: detect at frame offset %0d, required %0d", c % 16, SW - 1);
            end
         end
         if (c == 47) bus1.data_valid = 1'b0;
         @(negedge clk);
      end
      tests++;
      if (det != 3) begin
         fails++;
         $display("FAIL loop_count: detections=%0d, required 3", det);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus1.data_in    = '0;
      bus1.data_valid = 1'b0;
      bus3.data_in    = '0;
      bus3.data_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_frame(8'hA5, 1'b0);
      test_frame(8'h01, 1'b1);
      for (int i = 0; i < 6; i++) test_frame(DW'($urandom), 1'b1);
      test_back_to_back();
      test_slow_bits();
      test_reset_abort();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_tx_1011.md
SEQ_TX_1011 -- requirements
Module: seq_tx_1011

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
REQ-002 DATA_W, 8, payload width in bits (>=1).
REQ-003 SYNC_PATTERN, 4'b1011, sync word sent MSB first at frame start.
REQ-004 SYNC_W, 4, width of SYNC_PATTERN.
REQ-005 GAP_BITS, 2, zero bits forced after each frame (>=1).
REQ-006 CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1).
REQ-007 The block SHALL have these ports (name direction width meaning):
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 data_in  input  DATA_W  payload word to transmit.
REQ-011 data_valid  input  1  payload offer from upstream.
REQ-012 data_ready  output  1  block can accept a payload this cycle.
REQ-013 out_bit  output  1  registered serial bit stream toward the 1011 detector.
REQ-014 tx_busy  output  1  high while a frame or gap is in progress.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each frame's parity bit.

Function
REQ-016 States SHALL be IDLE, SYNC, DATA, PARITY, GAP; state, bit counter and clock-divider counter are registered.
REQ-017 data_ready SHALL be 1 only in IDLE; a payload is accepted on a rising edge where data_valid && data_ready.
REQ-018 On acceptance, data_in SHALL be captured into an internal shift register; later data_in changes have no effect on the frame.
REQ-019 data_valid while data_ready=0 SHALL be ignored (no capture, no queuing).
REQ-020 Frame SHALL be: SYNC_W sync bits MSB first, then DATA_W payload bits MSB first, then one even-parity bit (XOR of all payload bits), then GAP_BITS zero bits.
REQ-021 The first sync bit SHALL appear on out_bit in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-022 Each bit SHALL be held on out_bit for exactly CLKS_PER_BIT consecutive cycles; no bit is shortened or repeated.
REQ-023 Transitions: IDLE->SYNC on accept; SYNC->DATA after SYNC_W bits; DATA->PARITY after DATA_W bits; PARITY->GAP after the parity bit; GAP->IDLE after GAP_BITS bits.
REQ-024 out_bit SHALL be 0 in IDLE and GAP.
REQ-025 tx_busy SHALL be 1 in SYNC, DATA, PARITY, GAP and 0 in IDLE.
REQ-026 frame_done SHALL be 1 for exactly one cycle: the first GAP cycle of each frame.
REQ-027 With data_valid held high, consecutive frames SHALL be separated by exactly GAP_BITS*CLKS_PER_BIT+1 cycles of out_bit=0 (gap plus one IDLE cycle).
REQ-028 Counters SHALL be sized for max(SYNC_W, DATA_W, GAP_BITS) and CLKS_PER_BIT without overflow; no wrap-around mid-bit.

Reset
REQ-029 While reset=1 at a rising edge, next cycle SHALL have state=IDLE, out_bit=0, data_ready=1, tx_busy=0, frame_done=0, counters and shift register cleared.
REQ-030 Reset mid-frame SHALL abort the frame with no further frame bits emitted and no frame_done pulse.
REQ-031 reset=1 together with data_valid=1 SHALL not accept the payload.

Verification
REQ-032 Defaults, data_in=8'hA5 accepted at edge N -> out_bit cycles N+1..N+13 = 1,0,1,1,1,0,1,0,0,1,0,1,0 (parity 0), then 0,0; frame_done high at cycle N+14 only.
REQ-033 Defaults, data_in=8'h01 -> parity bit 1; out_bit = 1011 00000001 1 then 00; data_in changed to 8'hFF mid-frame does not alter the stream.
REQ-034 data_valid held high, payloads 8'h3C then 8'hC3 -> exactly 3 zero cycles between frames; data_ready high only in the single IDLE cycle between them.
REQ-035 CLKS_PER_BIT=3, data_in=8'hA5 -> each bit of REQ-032 held 3 cycles; frame_done still a single-cycle pulse; tx_busy high for 45 cycles.
REQ-036 reset asserted during DATA bit 3 -> next cycle out_bit=0, data_ready=1, tx_busy=0, no frame_done; new payload accepted and sent correctly afterwards.
REQ-037 Loopback: out_bit fed to the 1011 detector, default frames with payload 8'h00 -> detector flags exactly once per frame, at end of the sync word.
